fifo_reader: RTL
================

# fifo_reader

Read-side controller for the team's dual-clock `fifo`. It runs in the consumer clock domain and drives the FIFO's `clk_o` pop strobe from a registered FSM. It synchronizes the FIFO's combinational `status[2:0]`, captures the FIFO's `data_o` after each pop, and presents words downstream on a valid/ready handshake. It never pops an empty FIFO and never drops a word once it has been captured.

## Interface
Parameters:
- `n`, 8: data width; must match the attached `fifo` (2, 4, 8, 16).
- `g`, 0: extra idle cycles after each handshake before the next pop decision, for pacing.
- `cw`, 16: width of the popped-word counter.

Ports:
- `clk` in 1: consumer clock; all state is updated on its posedge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: permits new pops; a transaction already in progress always completes.
- `f_status` in 3: FIFO `status` output, asynchronous to `clk`.
- `f_data` in n: FIFO `data_o` output.
- `f_clk_o` out 1: pop strobe to FIFO `clk_o`; registered, glitch-free.
- `data_o` out n: captured word.
- `valid` out 1: `data_o` holds an unconsumed word.
- `ready` in 1: downstream accepts `data_o`.
- `level` out 3: synchronized `f_status`.
- `count` out cw: number of words handed downstream; wraps modulo 2^cw.

## Operation
- **Status synchronizer**
  - `f_status` passes through a 2-FF synchronizer, bitwise; the result is `level`.
  - `nonempty = (level != 3'b000)`.
  - Bitwise sync is safe here: the 000↔001 transitions flip a single bit, and only this block decreases the fill level.
- **FSM states:** IDLE, POP, SETTLE, HOLD, GUARD.
  - IDLE: if `en && nonempty`, go to POP. Otherwise stay.
  - POP: `f_clk_o = 1` for exactly one cycle; the FIFO pops on this rising edge. Go to SETTLE.
  - SETTLE: `f_clk_o = 0`. At the exiting edge, `data_o <= f_data` and `valid <= 1`. Go to HOLD.
  - HOLD: `valid = 1`, `data_o` stable. On an edge with `ready = 1`: `valid <= 0`, `count <= count + 1`, then go to GUARD if `g > 0`, else IDLE.
  - GUARD: counts g cycles, then goes to IDLE.
- `f_clk_o` is high only in POP, so every high pulse is exactly one `clk` period long.
- `en` is sampled only in IDLE. Deasserting it mid-transaction does not abort that transaction.
- The FIFO returns 0 when popped empty. The block prevents this: the decision in IDLE uses `level`, which is at least 3 edges newer than the previous pop (POP, SETTLE and HOLD each take one edge). The synchronized level therefore already reflects the previous pop.
- `count` wraps from 2^cw−1 to 0 with no flag.

## Timing
- Reset values: `f_clk_o = 0`, `data_o = 0`, `valid = 0`, `count = 0`, `level = 000`, state IDLE, synchronizer flops 0.
- Reset is asynchronous: `f_clk_o` and `valid` fall immediately.
  - If reset cuts a POP pulse short, the FIFO has already popped on the rising edge and that word is lost. This is accepted behaviour.
- Fill-level latency: a FIFO level change appears on `level` 2 `clk` edges later. The first pop decision comes at the 3rd edge after `f_status` becomes nonzero.
- Pop latency: from the IDLE edge that decides to pop, `valid` rises at edge +2 and `data_o` is valid at that same edge.
- Handshake:
  - Transfer occurs at an edge with `valid && ready`.
  - Valid may not be retracted; data stays stable while `valid && !ready`.
  - `ready` may be held high constantly.
- Throughput with `ready` tied high: one word per 4+g cycles (IDLE, POP, SETTLE, HOLD, plus g).
- Continuous `ready = 0`: the block stalls in HOLD and `f_clk_o` stays low indefinitely.

## Structure
- Shared package `fifo_pkg`:
  - Status constants `ST_EMPTY = 000`, `ST_Q1 = 001`, `ST_Q2 = 010`, `ST_Q3 = 011`, `ST_NEARFULL = 100`, `ST_FULL = 101`, shared with `fifo`.
  - FSM state encoding.
- Sub-module `sync2` (parameterized width, 2-FF synchronizer, async reset) instantiated for `f_status`. It is reusable elsewhere.
- The FSM, capture register, GUARD counter and `count` live in `fifo_reader` itself.

## Test plan
- **Reset/idle:** `rst` pulse, `f_status = 000` for 20 cycles → `f_clk_o` never high, `valid = 0`, `data_o = 0`, `count = 0`.
- **Single word:** real `fifo` (n=8, m=512) with 0xA5 written, `ready = 1`, g=0 → exactly one 1-cycle `f_clk_o` pulse, then `valid` for one cycle with `data_o = 0xA5`, then `count = 1` and no further pulses.
- **Burst drain/backpressure:** write 0x01..0x10, `ready` toggled 1/0 every cycle → 16 words in order, each held stable while `ready = 0`, `count = 16`, FIFO `status` ends at 000, zero pops on empty.
- **Wrap/throughput:** cw=4, 20 words, `ready = 1`, g=2 → `count` reads 4 (20 mod 16); pulses spaced exactly 6 cycles apart.
- **en gating:** deassert `en` during HOLD → current word still delivered, then no `f_clk_o` pulse while FIFO is nonempty; reassert `en` → draining resumes within 1 cycle of IDLE.
- **Reset mid-op:** assert `rst` while in POP → `f_clk_o` and `valid` fall asynchronously; after release, the next word (second-oldest) is delivered correctly.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the dual-clock fifo and its read-side
// controller fifo_reader.
//   - status encodings driven on the fifo's status[2:0] output
//   - fifo_reader FSM state encoding
package fifo_pkg;

  // Fill-level codes reported by the fifo. Only the EMPTY/Q1 boundary matters
  // to the reader: it is the one transition the reader itself causes.
  localparam logic [2:0] ST_EMPTY    = 3'b000;
  localparam logic [2:0] ST_Q1       = 3'b001;
  localparam logic [2:0] ST_Q2       = 3'b010;
  localparam logic [2:0] ST_Q3       = 3'b011;
  localparam logic [2:0] ST_NEARFULL = 3'b100;
  localparam logic [2:0] ST_FULL     = 3'b101;

  // Reader FSM states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,  // waiting for en && nonempty
    S_POP    = 3'd1,  // pop strobe high for this one cycle
    S_SETTLE = 3'd2,  // fifo data_o settling; captured at the exiting edge
    S_HOLD   = 3'd3,  // word presented downstream, waiting for ready
    S_GUARD  = 3'd4   // pacing gap of g cycles before the next decision
  } rd_state_t;

endpackage

// File: rtl/sync2.sv
// sync2: plain two-flop synchronizer, applied bitwise, with asynchronous
// active-high reset. Only safe for buses where at most one bit changes per
// transition (or where the consumer tolerates a one-cycle skew between bits).
// Ports:
//   clk  in  destination clock
//   rst  in  async active-high reset, clears both stages
//   d    in  W-bit signal from another clock domain
//   q    out W-bit synchronized copy, two clk edges behind d
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for the dual-clock fifo, running in the
// consumer clock domain. It synchronizes the fifo's fill status, pops one word
// at a time with a registered one-cycle strobe on f_clk_o, captures the popped
// word and offers it downstream.
//
// Downstream handshake: a word transfers on any clk edge where valid && ready.
// Once valid is high it stays high, with data_o unchanged, until that edge;
// ready may be held high permanently.
//
// Ports:
//   clk        in   consumer clock
//   rst        in   async active-high reset
//   en         in   allows new pops (sampled in IDLE only)
//   f_status   in   fifo status[2:0], asynchronous to clk
//   f_data     in   fifo data_o
//   f_clk_o    out  pop strobe to fifo clk_o, one clk period wide
//   data_o     out  captured word
//   valid      out  data_o holds an unconsumed word
//   ready      in   downstream accepts data_o
//   level      out  synchronized f_status
//   count      out  words handed downstream, wraps modulo 2^cw
//   dbg_state  out  current FSM state (rd_state_t encoding)
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int n  = 8,
  parameter int g  = 0,
  parameter int cw = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    f_status,
  input  logic [n-1:0]  f_data,
  output logic          f_clk_o,
  output logic [n-1:0]  data_o,
  output logic          valid,
  input  logic          ready,
  output logic [2:0]    level,
  output logic [cw-1:0] count,
  output logic [2:0]    dbg_state
);

  localparam int GW = (g > 1) ? $clog2(g) : 1;

  rd_state_t     state_q, state_d;
  logic [GW-1:0] gcnt_q;
  logic          nonempty;
  logic          take;

  // Bitwise sync is adequate: the reader is the only party lowering the fill
  // level, so the 001->000 edge it depends on is a single-bit change.
  sync2 #(.W(3)) u_status_sync (
    .clk (clk),
    .rst (rst),
    .d   (f_status),
    .q   (level)
  );

  assign nonempty  = (level != ST_EMPTY);
  assign take      = (state_q == S_HOLD) && ready;
  assign dbg_state = state_q;

  // Next-state logic. The IDLE decision sees a level at least three edges
  // after the previous pop (POP, SETTLE, HOLD), so it already reflects it and
  // an empty fifo is never popped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (en && nonempty) state_d = S_POP;
      S_POP:    state_d = S_SETTLE;
      S_SETTLE: state_d = S_HOLD;
      S_HOLD:   if (ready) state_d = (g > 0) ? S_GUARD : S_IDLE;
      S_GUARD:  if (gcnt_q == GW'(g - 1)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      f_clk_o <= 1'b0;
      data_o  <= '0;
      valid   <= 1'b0;
      count   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      // Strobe is a flop decoded from the next state: glitch-free and high
      // for exactly the one cycle spent in POP.
      f_clk_o <= (state_d == S_POP);

      if (state_q == S_SETTLE) begin
        data_o <= f_data;
        valid  <= 1'b1;
      end

      if (take) begin
        valid <= 1'b0;
        count <= count + cw'(1);
      end

      // GUARD dwell counter; held at zero outside GUARD.
      if (state_q == S_GUARD) gcnt_q <= gcnt_q + GW'(1);
      else                    gcnt_q <= '0;
    end
  end

endmodule
